// File: rtl/uart_tx_stream.sv
// Buffered UART transmitter: valid/ready byte stream in, framed serial line out.
// Frame format (baud, parity, stop bits, gap) is sampled per frame when a character is popped.
module uart_tx_stream #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [15:0]                   baud_div,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  input  logic [7:0]                    gap_bits,
  input  logic                          tx_enable,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx_out,
  output logic                          tx_busy,
  output logic                          tx_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              frames_sent
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;

  state_t               state;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [DATA_BITS-1:0] shifter;
  logic [15:0]          bit_timer;
  logic [15:0]          baud_m1;
  logic [15:0]          baud_m1_in;
  logic [7:0]           bit_idx;
  logic [7:0]           gap_l;
  logic                 parity_on;
  logic                 parity_odd;
  logic                 parity_bit;
  logic                 two_stop_l;
  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic                 stop_last;
  logic                 frame_end;
  logic                 busy_next;
  logic [LW-1:0]        level_next;

  assign in_ready   = (fifo_level != LW'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign bit_end    = (bit_timer == 16'd0);
  assign baud_m1_in = (baud_div == 16'd0) ? 16'd0 : baud_div - 16'd1;

  // A frame may end on the last stop clock or the last gap clock; popping right there
  // lets the next start bit follow with no idle cycle in between.
  assign stop_last  = (state == STOP) && bit_end && (!two_stop_l || bit_idx == 8'd1);
  assign frame_end  = (stop_last && gap_l == 8'd0) ||
                      ((state == GAP) && bit_end && bit_idx == gap_l - 8'd1);
  assign pop        = tx_enable && (fifo_level != '0) && ((state == IDLE) || frame_end);
  assign busy_next  = (state == IDLE) ? pop : !(frame_end && !pop);
  assign level_next = fifo_level + LW'(push) - LW'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= level_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tx_out      <= 1'b1;
      tx_busy     <= 1'b0;
      tx_empty    <= 1'b1;
      frames_sent <= '0;
      shifter     <= '0;
      bit_timer   <= '0;
      baud_m1     <= '0;
      bit_idx     <= '0;
      gap_l       <= '0;
      parity_on   <= 1'b0;
      parity_odd  <= 1'b0;
      parity_bit  <= 1'b0;
      two_stop_l  <= 1'b0;
    end else begin
      tx_busy  <= busy_next;
      tx_empty <= (level_next == '0) && !busy_next;
      if (stop_last) frames_sent <= frames_sent + CNT_W'(1);

      if (pop) begin
        shifter    <= mem[rd_ptr];
        parity_bit <= ^mem[rd_ptr];
        baud_m1    <= baud_m1_in;
        bit_timer  <= baud_m1_in;
        parity_on  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
        parity_odd <= (parity_mode == 2'b01);
        two_stop_l <= two_stop;
        gap_l      <= gap_bits;
        bit_idx    <= '0;
        tx_out     <= 1'b0;
        state      <= START;
      end else if (state != IDLE) begin
        if (!bit_end) begin
          bit_timer <= bit_timer - 16'd1;
        end else begin
          bit_timer <= baud_m1;
          case (state)
            START: begin
              tx_out  <= shifter[0];
              bit_idx <= '0;
              state   <= DATA;
            end
            DATA: begin
              if (bit_idx == 8'(DATA_BITS - 1)) begin
                bit_idx <= '0;
                if (parity_on) begin
                  tx_out <= parity_bit ^ parity_odd;
                  state  <= PARITY;
                end else begin
                  tx_out <= 1'b1;
                  state  <= STOP;
                end
              end else begin
                shifter <= shifter >> 1;
                tx_out  <= shifter[1];
                bit_idx <= bit_idx + 8'd1;
              end
            end
            PARITY: begin
              tx_out  <= 1'b1;
              bit_idx <= '0;
              state   <= STOP;
            end
            STOP: begin
              if (!stop_last) begin
                bit_idx <= bit_idx + 8'd1;
              end else if (gap_l != 8'd0) begin
                bit_idx <= '0;
                state   <= GAP;
              end else begin
                state <= IDLE;
              end
            end
            GAP: begin
              if (frame_end) state <= IDLE;
              else           bit_idx <= bit_idx + 8'd1;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Scoreboard bench for uart_tx_stream: accepted characters queue up as expected frames,
// and a line monitor rebuilds each frame clock-by-clock from the format rules and compares.
module tb_uart_tx_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        two_stop;
  logic [7:0]  gap_bits;
  logic        tx_enable;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        tx_out;
  logic        tx_busy;
  logic        tx_empty;
  logic [4:0]  fifo_level;
  logic [15:0] frames_sent;

  int         n_checks = 0;
  int         n_fail = 0;
  int         cycle = 0;
  int         model_frames = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  uart_tx_stream #(.DATA_BITS(8), .FIFO_DEPTH(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .baud_div(baud_div), .parity_mode(parity_mode),
    .two_stop(two_stop), .gap_bits(gap_bits), .tx_enable(tx_enable),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .tx_out(tx_out),
    .tx_busy(tx_busy), .tx_empty(tx_empty), .fifo_level(fifo_level),
    .frames_sent(frames_sent)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One push attempt after `idle` quiet cycles; held until the FIFO has room.
  task automatic applyStimulus(input logic [7:0] data, input int idle);
    int waited = 0;
    repeat (idle) @(posedge clk);
    @(posedge clk); #1;
    in_data  = data;
    in_valid = 1'b1;
    while (!in_ready && waited < 5000) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("push_accepted", 32'(in_ready), 1);
    if (in_ready) begin
      exp_q.push_back(data);
      model_frames++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    bit done = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (tx_empty && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput("drain_within_budget", 32'(done), 1);
  endtask

  // Line monitor: on a start bit, expand the next expected character into its bit list
  // using the format currently driven and compare every clock of the frame.
  initial begin : monitor
    forever begin
      logic [7:0] d;
      logic       bits[$];
      int         b;
      int         errs;
      bit         aborted;
      @(negedge clk);
      if (!reset && tx_out === 1'b0) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_frame", 32'(exp_q.size()), 1);
          while (tx_out === 1'b0 && !reset) @(negedge clk);
        end else begin
          d = exp_q.pop_front();
          start_q.push_back(cycle);
          b = (baud_div == 0) ? 1 : int'(baud_div);
          bits.delete();
          bits.push_back(1'b0);
          for (int i = 0; i < 8; i++) bits.push_back(d[i]);
          if (parity_mode == 2'b10) bits.push_back(^d);
          if (parity_mode == 2'b01) bits.push_back(~^d);
          bits.push_back(1'b1);
          if (two_stop) bits.push_back(1'b1);
          for (int i = 0; i < int'(gap_bits); i++) bits.push_back(1'b1);
          errs = 0;
          aborted = 1'b0;
          for (int s = 0; s < bits.size() * b; s++) begin
            if (s > 0) @(negedge clk);
            if (reset) begin
              aborted = 1'b1;
              break;
            end
            if (tx_out !== bits[s / b]) errs++;
          end
          if (!aborted) checkOutput($sformatf("frame_%02h_bits", d), 32'(errs), 0);
        end
      end
    end
  end

  initial begin : stimulus
    int bc;
    int accepted;
    int errs;
    bit seen;
    reset = 1'b1; baud_div = 16'd4; parity_mode = 2'b00; two_stop = 1'b0;
    gap_bits = 8'd0; tx_enable = 1'b1; in_data = 8'h00; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_tx_out", 32'(tx_out), 1);
    checkOutput("reset_tx_busy", 32'(tx_busy), 0);
    checkOutput("reset_tx_empty", 32'(tx_empty), 1);
    checkOutput("reset_fifo_level", 32'(fifo_level), 0);
    checkOutput("reset_frames_sent", 32'(frames_sent), 0);
    reset = 1'b0;
    checkOutput("reset_in_ready", 32'(in_ready), 1);

    // Single 8N1 frame with latency and total length
    applyStimulus(8'h55, 0);
    checkOutput("latency_line_still_idle", 32'(tx_out), 1);
    checkOutput("latency_level_one", 32'(fifo_level), 1);
    @(posedge clk); #1;
    checkOutput("start_bit_low", 32'(tx_out), 0);
    checkOutput("busy_after_pop", 32'(tx_busy), 1);
    checkOutput("level_after_pop", 32'(fifo_level), 0);
    bc = 1;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (!tx_busy) break;
      bc++;
    end
    checkOutput("frame_clocks_8n1", 32'(bc), 32'(4 * (1 + 8 + 1)));
    checkOutput("empty_after_frame", 32'(tx_empty), 1);
    checkOutput("frames_sent_one", 32'(frames_sent), 32'(model_frames));

    // Parity: even then odd on 0x07
    parity_mode = 2'b10;
    applyStimulus(8'h07, 0);
    wait_idle(1000);
    parity_mode = 2'b01;
    applyStimulus(8'h07, 0);
    wait_idle(1000);
    parity_mode = 2'b00;

    // Full FIFO with the transmitter paused
    start_q.delete();
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      tx_enable = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'(i);
      if (in_ready) begin
        accepted++;
        exp_q.push_back(8'(i));
        model_frames++;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("full_accepted", 32'(accepted), 16);
    checkOutput("full_level", 32'(fifo_level), 16);
    checkOutput("full_in_ready_low", 32'(in_ready), 0);
    checkOutput("paused_no_start", 32'(tx_out), 1);
    tx_enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (fifo_level == 5'd15) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("resume_pop", 32'(seen), 1);
    in_valid = 1'b1;
    in_data  = 8'h10;
    checkOutput("refill_ready", 32'(in_ready), 1);
    if (in_ready) begin
      exp_q.push_back(8'h10);
      model_frames++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("refill_level", 32'(fifo_level), 16);
    wait_idle(5000);
    checkOutput("full_frame_count", 32'(start_q.size()), 17);
    errs = 0;
    for (int i = 1; i < start_q.size(); i++)
      if (start_q[i] - start_q[i-1] != 40) errs++;
    checkOutput("back_to_back_spacing", 32'(errs), 0);
    checkOutput("frames_sent_after_full", 32'(frames_sent), 32'(model_frames & 16'hFFFF));

    // Format switch: the mid-frame baud change applies only to the second frame
    baud_div = 16'd2; two_stop = 1'b1; gap_bits = 8'd3;
    start_q.delete();
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h3C, 0);
    repeat (6) @(posedge clk);
    #1;
    baud_div = 16'd3;
    wait_idle(2000);
    checkOutput("format_frame_count", 32'(start_q.size()), 2);
    if (start_q.size() == 2)
      checkOutput("start_to_start", 32'(start_q[1] - start_q[0]), 32'(2 * (1 + 8 + 2 + 3)));

    // Reset during the data bits of frame 2 of 4
    baud_div = 16'd4; two_stop = 1'b0; gap_bits = 8'd0;
    start_q.delete();
    for (int i = 0; i < 4; i++) applyStimulus(8'(8'h31 + i), 0);
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (start_q.size() >= 2) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("frame2_started", 32'(seen), 1);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_tx_out", 32'(tx_out), 1);
    checkOutput("abort_fifo_level", 32'(fifo_level), 0);
    checkOutput("abort_frames_sent", 32'(frames_sent), 0);
    checkOutput("abort_tx_busy", 32'(tx_busy), 0);
    reset = 1'b0;
    exp_q.delete();
    model_frames = 0;
    repeat (200) @(posedge clk);
    #1;
    checkOutput("no_frames_after_abort", 32'(start_q.size()), 2);
    checkOutput("idle_after_abort", 32'(tx_empty), 1);

    // baud_div = 0 behaves as one clock per bit
    baud_div = 16'd0;
    applyStimulus(8'hFF, 0);
    bc = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (!tx_busy) break;
      bc++;
    end
    checkOutput("frame_clocks_div0", 32'(bc), 10);

    // Randomised segments: format held per segment, pushes and pauses random
    for (int seg = 0; seg < 4; seg++) begin
      baud_div    = 16'($urandom_range(0, 5));
      parity_mode = 2'($urandom_range(0, 3));
      two_stop    = 1'($urandom_range(0, 1));
      gap_bits    = 8'($urandom_range(0, 3));
      for (int i = 0; i < 12; i++) begin
        tx_enable = ($urandom_range(0, 3) != 0);
        applyStimulus(8'($urandom), $urandom_range(0, 6));
      end
      tx_enable = 1'b1;
      wait_idle(20000);
      checkOutput($sformatf("frames_sent_seg%0d", seg), 32'(frames_sent),
                  32'(model_frames & 16'hFFFF));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
